// File: rtl/pchb_pkg.sv
// Shared types, dual-rail constants and decode helpers for the PCHB split.
package pchb_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_NEUT = 2'd2
  } state_e;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ILL  = 2'b11;

  function automatic logic dr_valid(input logic [1:0] ch);
    return ch[0] ^ ch[1];
  endfunction

  function automatic logic dr_null(input logic [1:0] ch);
    return ch == DR_NULL;
  endfunction

endpackage

// File: rtl/pchb_split_if.sv
// Dual-rail channel bundle of the split: input L with SELECT, outputs R0 and R1.
// Handshake (four-phase return-to-zero, every channel): the receiver raises its
// enable to request a token; the sender drives one rail high; the receiver drops
// the enable to acknowledge; the sender returns the rails to 00; the enable rises
// again to request the next token.
interface pchb_split_if;
  logic [1:0] L;
  logic       Le;
  logic [1:0] SELECT;
  logic       SELECTe;
  logic [1:0] R0;
  logic       R0e;
  logic [1:0] R1;
  logic       R1e;

  modport master (
    output L, SELECT, R0e, R1e,
    input  Le, SELECTe, R0, R1
  );

  modport slave (
    input  L, SELECT, R0e, R1e,
    output Le, SELECTe, R0, R1
  );
endinterface

// File: rtl/pchb_split_dr_check.sv
// Decodes one dual-rail channel into valid / neutral / illegal flags.
module dr_check
  import pchb_pkg::*;
(
  input  logic [1:0] ch,
  output logic       valid,
  output logic       neutral,
  output logic       illegal
);

  assign valid   = dr_valid(ch);
  assign neutral = dr_null(ch);
  assign illegal = (ch == DR_ILL);

endmodule

// File: rtl/pchb_split.sv
// Precharge half-buffer split: steers one dual-rail token from L to R0 or R1
// according to SELECT, with per-output transfer counters and a sticky error flag.
module pchb_split
  import pchb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  pchb_split_if.slave      bus,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1,
  output logic             ERR,
  output state_e           dbg_state
);

  state_e           state_q, state_n;
  logic             idx_q, idx_n;
  logic [1:0]       data_q, data_n;
  logic             le_q, le_n;
  logic [1:0]       r0_q, r0_n;
  logic [1:0]       r1_q, r1_n;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             err_q;

  logic l_valid, l_null, l_ill;
  logic s_valid, s_null, s_ill;

  dr_check u_chk_l (.ch(bus.L),      .valid(l_valid), .neutral(l_null), .illegal(l_ill));
  dr_check u_chk_s (.ch(bus.SELECT), .valid(s_valid), .neutral(s_null), .illegal(s_ill));

  logic sel_idx, sel_ready, idx_ready, capture, release_tok;

  // SELECT[1] high routes to R1, SELECT[0] high routes to R0.
  assign sel_idx     = bus.SELECT[1];
  assign sel_ready   = sel_idx ? bus.R1e : bus.R0e;
  assign idx_ready   = idx_q ? bus.R1e : bus.R0e;
  assign capture     = (state_q == S_WAIT) && l_valid && s_valid && sel_ready;
  assign release_tok = (state_q == S_HOLD) && !idx_ready;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_WAIT;
      idx_q   <= 1'b0;
      data_q  <= DR_NULL;
      le_q    <= 1'b1;
      r0_q    <= DR_NULL;
      r1_q    <= DR_NULL;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      le_q    <= le_n;
      r0_q    <= r0_n;
      r1_q    <= r1_n;
      err_q   <= err_q | l_ill | s_ill;
      if (release_tok) begin
        if (idx_q) cnt1_q <= cnt1_q + CNT_W'(1);
        else       cnt0_q <= cnt0_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_WAIT:  if (capture) state_n = S_HOLD;
      S_HOLD:  if (!idx_ready) state_n = S_NEUT;
      S_NEUT:  if (l_null && s_null && idx_ready) state_n = S_WAIT;
      default: state_n = S_WAIT;
    endcase
  end

  // Outputs are computed from the next state so they become visible right after the edge.
  always_comb begin
    idx_n  = capture ? sel_idx : idx_q;
    data_n = capture ? bus.L   : data_q;
    le_n   = (state_n == S_WAIT);
    r0_n   = ((state_n == S_HOLD) && !idx_n) ? data_n : DR_NULL;
    r1_n   = ((state_n == S_HOLD) &&  idx_n) ? data_n : DR_NULL;
  end

  assign bus.Le      = le_q;
  assign bus.SELECTe = le_q;
  assign bus.R0      = r0_q;
  assign bus.R1      = r1_q;
  assign CNT0        = cnt0_q;
  assign CNT1        = cnt1_q;
  assign ERR         = err_q;
  assign dbg_state   = state_q;

endmodule
